// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcode values, FSM state encoding,
// decoded opcode class and the control-word bundle driven to the datapath.
package cpu_pkg;

  localparam int OPCODE_W_DEF = 4;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JMI = 4'h5;
  localparam logic [3:0] OP_JEQ = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;
  localparam logic [3:0] OP_ASR = 4'hB;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // One-hot instruction class; exactly one field is set for any IR value.
  typedef struct packed {
    logic lda;
    logic sta;
    logic add;
    logic sub;
    logic jmp;
    logic jmi;
    logic jeq;
    logic stp;
    logic ldi;
    logic lsl;
    logic lsr;
    logic asr;
    logic ill;
  } op_class_t;

  typedef struct packed {
    logic ir_load;
    logic wren;
    logic mux1;
    logic mux3;
    logic mux3_all;
    logic pc_sload;
    logic pc_cnt_en;
    logic acc_en;
    logic acc_load;
    logic acc_shiftin;
    logic shift_left;
    logic addsub;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> RAM/PC/ACC datapath bundle: opcode and status flags in,
// control strobes out. master = sequencer side, slave = datapath side.
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF
);

  logic [OPCODE_W-1:0] op_in;
  logic                mem_ready;
  logic                EQ;
  logic                MI;
  logic                resume;

  logic ir_load;
  logic Wren;
  logic MUX1;
  logic MUX3;
  logic MUX3_useAllBits;
  logic PC_sload;
  logic PC_cnt_en;
  logic ACC_EN;
  logic ACC_LOAD;
  logic ACC_SHIFTIN;
  logic SHIFT_LEFT;
  logic ADDSUB;

  modport master (
    input  op_in, mem_ready, EQ, MI, resume,
    output ir_load, Wren, MUX1, MUX3, MUX3_useAllBits, PC_sload, PC_cnt_en,
           ACC_EN, ACC_LOAD, ACC_SHIFTIN, SHIFT_LEFT, ADDSUB
  );

  modport slave (
    output op_in, mem_ready, EQ, MI, resume,
    input  ir_load, Wren, MUX1, MUX3, MUX3_useAllBits, PC_sload, PC_cnt_en,
           ACC_EN, ACC_LOAD, ACC_SHIFTIN, SHIFT_LEFT, ADDSUB
  );

endinterface

// File: rtl/cpu_op_decode.sv
// Pure combinational IR decode into a one-hot instruction class. Any opcode
// with a set bit above bit 3, or in the range C-F, decodes as illegal.
module cpu_op_decode
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF
) (
  input  logic [OPCODE_W-1:0] ir,
  output op_class_t           cls
);

  logic wide;

  assign wide = (ir >> 4) != '0;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    cls = '0;
    if (wide) begin
      cls.ill = 1'b1;
    end else begin
      case (ir[3:0])
        OP_LDA:  cls.lda = 1'b1;
        OP_STA:  cls.sta = 1'b1;
        OP_ADD:  cls.add = 1'b1;
        OP_SUB:  cls.sub = 1'b1;
        OP_JMP:  cls.jmp = 1'b1;
        OP_JMI:  cls.jmi = 1'b1;
        OP_JEQ:  cls.jeq = 1'b1;
        OP_STP:  cls.stp = 1'b1;
        OP_LDI:  cls.ldi = 1'b1;
        OP_LSL:  cls.lsl = 1'b1;
        OP_LSR:  cls.lsr = 1'b1;
        OP_ASR:  cls.asr = 1'b1;
        default: cls.ill = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// CPU control sequencer: FETCH/EXEC1/EXEC2/HALT FSM, instruction register,
// control decode, sticky illegal-opcode flag and retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter bit PIPELINE = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_sequencer_if.master  bus,
  output logic [1:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] ir_q;
  logic                illegal_q;
  logic [CNT_W-1:0]    retired_q;

  op_class_t cls;
  ctrl_t     ctl;
  logic      retire;
  logic      set_illegal;
  logic      acc_terminal;
  logic      branch_taken;

  cpu_op_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .ir  (ir_q),
    .cls (cls)
  );

  always_comb begin
    state_d      = state_q;
    ctl          = CTRL_IDLE;
    retire       = 1'b0;
    set_illegal  = 1'b0;
    acc_terminal = 1'b0;
    branch_taken = cls.jmp | (cls.jmi & bus.MI) | (cls.jeq & bus.EQ);

    unique case (state_q)
      ST_FETCH: begin
        ctl.ir_load   = bus.mem_ready;
        ctl.pc_cnt_en = PIPELINE && bus.mem_ready;
        if (bus.mem_ready) state_d = ST_EXEC1;
      end

      ST_EXEC1: begin
        if (cls.lda || cls.add || cls.sub) begin
          ctl.mux1 = 1'b1;
          state_d  = ST_EXEC2;
        end else if (cls.sta) begin
          ctl.mux1      = 1'b1;
          ctl.wren      = 1'b1;
          ctl.pc_cnt_en = !PIPELINE;
          retire        = 1'b1;
          state_d       = ST_FETCH;
        end else if (cls.jmp || cls.jmi || cls.jeq) begin
          // With PIPELINE=1 the PC was already advanced during FETCH.
          ctl.pc_sload  = branch_taken;
          ctl.pc_cnt_en = !branch_taken && !PIPELINE;
          retire        = 1'b1;
          state_d       = ST_FETCH;
        end else if (cls.stp) begin
          retire  = 1'b1;
          state_d = ST_HALT;
        end else if (cls.ldi) begin
          ctl.acc_en   = 1'b1;
          ctl.acc_load = 1'b1;
          ctl.mux3     = 1'b1;
          acc_terminal = 1'b1;
        end else if (cls.lsl || cls.lsr || cls.asr) begin
          ctl.acc_en      = 1'b1;
          ctl.mux3_all    = 1'b1;
          ctl.shift_left  = cls.lsl;
          ctl.acc_shiftin = cls.asr & bus.MI;
          acc_terminal    = 1'b1;
        end else begin
          set_illegal = 1'b1;
          state_d     = ST_HALT;
        end
      end

      ST_EXEC2: begin
        ctl.acc_en   = 1'b1;
        ctl.acc_load = 1'b1;
        ctl.mux3     = cls.lda;
        ctl.mux3_all = cls.lda;
        ctl.addsub   = cls.add;
        acc_terminal = 1'b1;
      end

      ST_HALT: begin
        if (bus.resume) state_d = ST_FETCH;
      end
    endcase

    // Last cycle of an ACC-writing instruction: either overlap the next fetch
    // (ACC write still happens exactly once) or fall back to a plain FETCH.
    if (acc_terminal) begin
      retire = 1'b1;
      if (PIPELINE) begin
        ctl.mux1      = 1'b0;
        ctl.ir_load   = bus.mem_ready;
        ctl.pc_cnt_en = bus.mem_ready;
        state_d       = bus.mem_ready ? ST_EXEC1 : ST_FETCH;
      end else begin
        ctl.pc_cnt_en = 1'b1;
        state_d       = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ctl.ir_load) ir_q <= bus.op_in;
      if (set_illegal) illegal_q <= 1'b1;
      if (retire)      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.ir_load         = ctl.ir_load;
  assign bus.Wren            = ctl.wren;
  assign bus.MUX1            = ctl.mux1;
  assign bus.MUX3            = ctl.mux3;
  assign bus.MUX3_useAllBits = ctl.mux3_all;
  assign bus.PC_sload        = ctl.pc_sload;
  assign bus.PC_cnt_en       = ctl.pc_cnt_en;
  assign bus.ACC_EN          = ctl.acc_en;
  assign bus.ACC_LOAD        = ctl.acc_load;
  assign bus.ACC_SHIFTIN     = ctl.acc_shiftin;
  assign bus.SHIFT_LEFT      = ctl.shift_left;
  assign bus.ADDSUB          = ctl.addsub;

  assign state   = state_q;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: three instances (PIPELINE=0, PIPELINE=1,
// PIPELINE=1 with a 2-bit counter); a per-cycle scoreboard checks one of them.
module tb_cpu_sequencer;

  localparam logic [11:0] NONE = 12'h000;
  localparam logic [11:0] IRL  = 12'h800;
  localparam logic [11:0] WR   = 12'h400;
  localparam logic [11:0] M1   = 12'h200;
  localparam logic [11:0] M3   = 12'h100;
  localparam logic [11:0] MA   = 12'h080;
  localparam logic [11:0] SL   = 12'h040;
  localparam logic [11:0] CE   = 12'h020;
  localparam logic [11:0] AE   = 12'h010;
  localparam logic [11:0] AL   = 12'h008;
  localparam logic [11:0] SI   = 12'h004;
  localparam logic [11:0] SH   = 12'h002;
  localparam logic [11:0] AS   = 12'h001;

  typedef struct {
    int          dut;
    logic [1:0]  st;
    logic [11:0] ctl;
    logic        ill;
    logic [15:0] ret;
    string       name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] op_in;
  logic       mem_ready, eq, mi, resume;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  cpu_sequencer_if #(.OPCODE_W(4)) if0 ();
  cpu_sequencer_if #(.OPCODE_W(4)) if1 ();
  cpu_sequencer_if #(.OPCODE_W(4)) if2 ();

  assign if0.op_in = op_in;  assign if0.mem_ready = mem_ready;
  assign if0.EQ    = eq;     assign if0.MI = mi;  assign if0.resume = resume;
  assign if1.op_in = op_in;  assign if1.mem_ready = mem_ready;
  assign if1.EQ    = eq;     assign if1.MI = mi;  assign if1.resume = resume;
  assign if2.op_in = op_in;  assign if2.mem_ready = mem_ready;
  assign if2.EQ    = eq;     assign if2.MI = mi;  assign if2.resume = resume;

  logic [1:0]  st0, st1, st2;
  logic        h0, h1, h2, il0, il1, il2;
  logic [15:0] rt0, rt1;
  logic [1:0]  rt2;

  cpu_sequencer #(.OPCODE_W(4), .PIPELINE(1'b0), .CNT_W(16)) u_p0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master),
    .state(st0), .halted(h0), .illegal(il0), .retired(rt0));

  cpu_sequencer #(.OPCODE_W(4), .PIPELINE(1'b1), .CNT_W(16)) u_p1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master),
    .state(st1), .halted(h1), .illegal(il1), .retired(rt1));

  cpu_sequencer #(.OPCODE_W(4), .PIPELINE(1'b1), .CNT_W(2)) u_w (
    .clk(clk), .rst_n(rst_n), .bus(if2.master),
    .state(st2), .halted(h2), .illegal(il2), .retired(rt2));

  // Observed word: {state, 12 control bits, halted, illegal, retired}
  logic [31:0] obs0, obs1, obs2;
  assign obs0 = {st0, if0.ir_load, if0.Wren, if0.MUX1, if0.MUX3, if0.MUX3_useAllBits,
                 if0.PC_sload, if0.PC_cnt_en, if0.ACC_EN, if0.ACC_LOAD, if0.ACC_SHIFTIN,
                 if0.SHIFT_LEFT, if0.ADDSUB, h0, il0, rt0};
  assign obs1 = {st1, if1.ir_load, if1.Wren, if1.MUX1, if1.MUX3, if1.MUX3_useAllBits,
                 if1.PC_sload, if1.PC_cnt_en, if1.ACC_EN, if1.ACC_LOAD, if1.ACC_SHIFTIN,
                 if1.SHIFT_LEFT, if1.ADDSUB, h1, il1, rt1};
  assign obs2 = {st2, if2.ir_load, if2.Wren, if2.MUX1, if2.MUX3, if2.MUX3_useAllBits,
                 if2.PC_sload, if2.PC_cnt_en, if2.ACC_EN, if2.ACC_LOAD, if2.ACC_SHIFTIN,
                 if2.SHIFT_LEFT, if2.ADDSUB, h2, il2, 14'd0, rt2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got state=%0d ctl=%03h halted=%b illegal=%b retired=%0d, expected state=%0d ctl=%03h halted=%b illegal=%b retired=%0d",
               name, act[31:30], act[29:18], act[17], act[16], act[15:0],
               exp[31:30], exp[29:18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // Monitor: every queued expectation is compared against the selected DUT
  // on the falling edge, mid-way between input changes and clock edges.
  exp_t        cur;
  logic [31:0] act_w, exp_w;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      case (cur.dut)
        0:       act_w = obs0;
        1:       act_w = obs1;
        default: act_w = obs2;
      endcase
      exp_w = {cur.st, cur.ctl, (cur.st == 2'd3), cur.ill, cur.ret};
      check(cur.name, act_w, exp_w);
    end
  end

  // Apply one cycle of inputs and queue the expected response for that cycle.
  task automatic cyc(input int d, input logic [3:0] op, input logic mr, input logic e,
                     input logic m, input logic r, input logic [1:0] st,
                     input logic [11:0] c, input logic il, input logic [15:0] rt,
                     input string nm);
    op_in = op; mem_ready = mr; eq = e; mi = m; resume = r;
    exp_q.push_back('{d, st, c, il, rt, nm});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    op_in = 4'h0; mem_ready = 1'b0; eq = 1'b0; mi = 1'b0; resume = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // PIPELINE=0: LDI; ADD; STP
    cyc(0, 4'h8, 1, 0, 0, 0, 2'd0, IRL,         0, 0, "p0_reset_fetch_ldi");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd1, AE|AL|M3|CE, 0, 0, "p0_ldi_exec1");
    cyc(0, 4'h2, 1, 0, 0, 0, 2'd0, IRL,         0, 1, "p0_fetch_add");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd1, M1,          0, 1, "p0_add_exec1");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd2, AE|AL|AS|CE, 0, 1, "p0_add_exec2");
    cyc(0, 4'h7, 1, 0, 0, 0, 2'd0, IRL,         0, 2, "p0_fetch_stp");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd1, NONE,        0, 2, "p0_stp_exec1");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd3, NONE,        0, 3, "p0_halt_hold");
    cyc(0, 4'h0, 0, 0, 0, 1, 2'd3, NONE,        0, 3, "p0_halt_resume");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd0, NONE,        0, 3, "p0_after_resume");

    // PIPELINE=0: branches, STA, LDA, then async reset in ADD EXEC2
    do_reset();
    cyc(0, 4'h5, 1, 0, 0, 0, 2'd0, IRL,            0, 0, "p0_fetch_jmi");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd1, CE,             0, 0, "p0_jmi_not_taken");
    cyc(0, 4'h5, 1, 0, 0, 0, 2'd0, IRL,            0, 1, "p0_fetch_jmi2");
    cyc(0, 4'h0, 0, 0, 1, 0, 2'd1, SL,             0, 1, "p0_jmi_taken");
    cyc(0, 4'h6, 1, 0, 0, 0, 2'd0, IRL,            0, 2, "p0_fetch_jeq");
    cyc(0, 4'h0, 0, 1, 0, 0, 2'd1, SL,             0, 2, "p0_jeq_taken");
    cyc(0, 4'h1, 1, 0, 0, 0, 2'd0, IRL,            0, 3, "p0_fetch_sta");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd1, M1|WR|CE,       0, 3, "p0_sta_exec1");
    cyc(0, 4'h0, 1, 0, 0, 0, 2'd0, IRL,            0, 4, "p0_fetch_lda");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd1, M1,             0, 4, "p0_lda_exec1");
    cyc(0, 4'h0, 1, 0, 0, 0, 2'd2, AE|AL|M3|MA|CE, 0, 4, "p0_lda_exec2");
    cyc(0, 4'h2, 1, 0, 0, 0, 2'd0, IRL,            0, 5, "p0_fetch_add2");
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd1, M1,             0, 5, "p0_add2_exec1");
    // Reset asserted mid-cycle while in EXEC2: outputs must clear before any edge.
    op_in = 4'h0; mem_ready = 1'b0; eq = 1'b0; mi = 1'b0; resume = 1'b0;
    exp_q.push_back('{0, 2'd0, NONE, 1'b0, 16'd0, "p0_async_reset_exec2"});
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(0, 4'h0, 0, 0, 0, 0, 2'd0, NONE,           0, 0, "p0_after_reset");

    // PIPELINE=1: LDI; LSR; LDA; ASR; LSL back-to-back, then stalls and branches
    do_reset();
    cyc(1, 4'h8, 1, 0, 0, 0, 2'd0, IRL|CE,             0, 0, "p1_fetch_ldi");
    cyc(1, 4'hA, 1, 0, 0, 0, 2'd1, AE|AL|M3|IRL|CE,    0, 0, "p1_ldi_overlap");
    cyc(1, 4'h0, 1, 0, 1, 0, 2'd1, AE|MA|IRL|CE,       0, 1, "p1_lsr_overlap");
    cyc(1, 4'hB, 1, 0, 0, 0, 2'd1, M1,                 0, 2, "p1_lda_exec1");
    cyc(1, 4'hB, 1, 0, 0, 0, 2'd2, AE|AL|M3|MA|IRL|CE, 0, 2, "p1_lda_overlap");
    cyc(1, 4'h9, 1, 0, 1, 0, 2'd1, AE|MA|SI|IRL|CE,    0, 3, "p1_asr_overlap");
    cyc(1, 4'h0, 0, 0, 1, 0, 2'd1, AE|MA|SH,           0, 4, "p1_lsl_no_ready");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd0, NONE,               0, 5, "p1_fetch_stall1");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd0, NONE,               0, 5, "p1_fetch_stall2");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd0, NONE,               0, 5, "p1_fetch_stall3");
    cyc(1, 4'h5, 1, 0, 0, 0, 2'd0, IRL|CE,             0, 5, "p1_fetch_jmi");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd1, NONE,               0, 5, "p1_jmi_not_taken");
    cyc(1, 4'h5, 1, 0, 0, 0, 2'd0, IRL|CE,             0, 6, "p1_fetch_jmi2");
    cyc(1, 4'h0, 0, 0, 1, 0, 2'd1, SL,                 0, 6, "p1_jmi_taken");
    cyc(1, 4'h2, 1, 0, 0, 0, 2'd0, IRL|CE,             0, 7, "p1_fetch_add");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd1, M1,                 0, 7, "p1_add_exec1");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd2, AE|AL|AS,           0, 7, "p1_add_exec2_no_ready");
    cyc(1, 4'h1, 1, 0, 0, 0, 2'd0, IRL|CE,             0, 8, "p1_fetch_sta");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd1, M1|WR,              0, 8, "p1_sta_exec1");

    // Illegal opcode traps to HALT, is not retired, and stays sticky past resume
    cyc(1, 4'hD, 1, 0, 0, 0, 2'd0, IRL|CE, 0, 9, "p1_fetch_illegal");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd1, NONE,   0, 9, "p1_illegal_exec1");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd3, NONE,   1, 9, "p1_illegal_halt");
    cyc(1, 4'h0, 0, 0, 0, 1, 2'd3, NONE,   1, 9, "p1_illegal_resume");
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd0, NONE,   1, 9, "p1_illegal_sticky");
    do_reset();
    cyc(1, 4'h0, 0, 0, 0, 0, 2'd0, NONE,   0, 0, "p1_illegal_cleared");

    // CNT_W=2: five LDIs retire, counter wraps to 1
    do_reset();
    cyc(2, 4'h8, 1, 0, 0, 0, 2'd0, IRL|CE,          0, 0, "w_fetch");
    cyc(2, 4'h8, 1, 0, 0, 0, 2'd1, AE|AL|M3|IRL|CE, 0, 0, "w_ldi1");
    cyc(2, 4'h8, 1, 0, 0, 0, 2'd1, AE|AL|M3|IRL|CE, 0, 1, "w_ldi2");
    cyc(2, 4'h8, 1, 0, 0, 0, 2'd1, AE|AL|M3|IRL|CE, 0, 2, "w_ldi3");
    cyc(2, 4'h8, 1, 0, 0, 0, 2'd1, AE|AL|M3|IRL|CE, 0, 3, "w_ldi4");
    cyc(2, 4'h0, 0, 0, 0, 0, 2'd1, AE|AL|M3,        0, 0, "w_ldi5_wrapped");
    cyc(2, 4'h0, 0, 0, 0, 0, 2'd0, NONE,            0, 1, "w_retired_1");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations never compared, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Parametrised successor to the CPU decode stage: merges the FETCH/EXEC1/EXEC2 state machine, instruction register and control decode into one sequential block.
- Adds an optional overlapped fetch (PIPELINE), a memory-ready wait, a HALT state with resume, illegal-opcode trap, LSL, and a retired-instruction counter.
- Sits between RAM/PC/ACC datapath and the top level; datapath flags (EQ, MI) stay external.

Parameters:
OPCODE_W, 4, IR opcode width (>=4); any opcode with a nonzero bit above bit 3 is illegal
PIPELINE, 1, 1 = overlap next fetch with terminal ACC-write cycle; 0 = strict 3-state sequence
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_in  in  OPCODE_W  opcode field of RAM read data, captured on ir_load
mem_ready  in  1  RAM read data valid this cycle
EQ  in  1  ACC == N
MI  in  1  ACC negative
resume  in  1  leave HALT (level, sampled only in HALT)
ir_load  out  1  IR <= op_in this cycle
Wren  out  1  RAM write
MUX1  out  1  1 = RAM address from IR operand, 0 = from PC
MUX3  out  1  1 = ACC load source RAM/immediate path selected (LDA, LDI)
MUX3_useAllBits  out  1  full 16-bit RAM word to ACC (LDA, shifts)
PC_sload  out  1  PC <= N
PC_cnt_en  out  1  PC += 1
ACC_EN  out  1  ACC write enable
ACC_LOAD  out  1  1 = load, 0 = shift (with ACC_EN)
ACC_SHIFTIN  out  1  bit shifted into vacated position
SHIFT_LEFT  out  1  1 = left shift (LSL), 0 = right
ADDSUB  out  1  1 = add, 0 = sub
state  out  2  FETCH=0, EXEC1=1, EXEC2=2, HALT=3
halted  out  1  state == HALT
illegal  out  1  sticky; set on illegal opcode, cleared by reset only
retired  out  CNT_W  instructions completed, wraps at 2^CNT_W

Behaviour:
- Opcodes: LDA 0, STA 1, ADD 2, SUB 3, JMP 4, JMI 5, JEQ 6, STP 7, LDI 8, LSL 9, LSR A, ASR B; C-F and wide-bit opcodes illegal.
- Reset (async): state FETCH, IR 0, illegal 0, retired 0; all control outputs are combinational from state/IR and are 0 except MUX1=0 in FETCH.
- FETCH: MUX1=0; ir_load=mem_ready; PIPELINE=1 also PC_cnt_en=mem_ready. mem_ready=0 -> hold FETCH, no side effects; else -> EXEC1.
- EXEC1: LDA/ADD/SUB: MUX1=1 -> EXEC2. STA: MUX1=1, Wren -> FETCH. JMP: PC_sload. JMI: PC_sload if MI. JEQ: PC_sload if EQ. PIPELINE=0: untaken branch, STA, LDI and shifts also assert PC_cnt_en. LDI: ACC_EN, ACC_LOAD, MUX3. LSL/LSR/ASR: ACC_EN, ACC_LOAD=0, MUX3_useAllBits; SHIFT_LEFT for LSL; ACC_SHIFTIN=MI for ASR, 0 otherwise. STP -> HALT. Illegal -> set illegal, -> HALT, no other control asserted.
- EXEC2: ACC_EN, ACC_LOAD; LDA adds MUX3, MUX3_useAllBits; ADD sets ADDSUB; PIPELINE=0 asserts PC_cnt_en. -> FETCH.
- Overlap (PIPELINE=1): in terminal cycle of LDI/shifts (EXEC1) and LDA/ADD/SUB (EXEC2), MUX1=0, ir_load=mem_ready, PC_cnt_en=mem_ready; next state EXEC1 if mem_ready else FETCH. ACC action is asserted exactly once regardless of mem_ready.
- HALT: all controls 0; resume=1 -> FETCH next cycle.
- retired += 1 on last cycle of each legal instruction, including STP; illegal opcode not counted.
- EQ/MI sampled combinationally in the cycle they are used.
- Reset mid-instruction: immediate return to FETCH; no partial write repeats.

Decomposition:
- Package cpu_pkg: opcode localparams, state encoding, OPCODE_W default.
- One sub-module cpu_op_decode (pure combinational IR -> one-hot op class); FSM, IR, counter in cpu_sequencer.

Test Plan:
- PIPELINE=0, program LDI; ADD; STP with mem_ready=1 -> states 0,1,0,1,2,0,1,3; retired=3; PC_cnt_en pulses in LDI EXEC1 and ADD EXEC2.
- PIPELINE=1, LDI; LSR; LDA back-to-back -> no FETCH between them; ir_load in each terminal cycle; ACC_EN once per instruction.
- JMI with MI=0 then MI=1 -> first: PC_cnt_en (P=0) / nothing (P=1); second: PC_sload=1, PC_cnt_en=0.
- mem_ready=0 for 3 cycles in FETCH and in an overlap cycle -> FETCH held, no ir_load; overlap falls back to FETCH with ACC_EN asserted once.
- op_in=4'hD -> illegal=1, HALT, retired unchanged; resume -> FETCH, illegal stays 1 until rst_n low.
- rst_n low during EXEC2 of ADD -> outputs zero asynchronously, state=0; retired wrap test with CNT_W=2: 5 instructions -> retired=1.
